// File: rtl/cherry_pkg.sv
// Shared definitions for the DMA tile path: tile geometry, DMA stage
// instruction layouts and the tile engine state encoding.
package cherry_pkg;

  localparam int TILE_WIDTH = 288;
  localparam int MEM_DW     = 32;
  localparam int BEATS      = TILE_WIDTH / MEM_DW;
  localparam int MEM_AW     = 17;

  localparam logic [1:0] SLOT_SINGLE_TILE = 2'd0;

  typedef struct packed {
    logic        valid;
    logic        mem_we;
    logic [1:0]  cache_slot;
    logic [4:0]  cache_addr;
    logic [12:0] mem_addr;
  } raw_instr_data_t;

  typedef struct packed {
    raw_instr_data_t raw_instr_data;
  } dma_stage_1_instr_t;

  typedef struct packed {
    dma_stage_1_instr_t      instr;
    logic [TILE_WIDTH-1:0]   dat;
  } dma_stage_2_instr_t;

  typedef dma_stage_2_instr_t dma_stage_3_instr_t;

  typedef enum logic [2:0] {
    IDLE, C_ISSUE, C_CAPT, M_WR, M_REQ, M_RESP, W_CACHE
  } dma_state_t;

  // Tiles are packed contiguously in memory, BEATS words per tile.
  function automatic logic [MEM_AW-1:0] beat_addr(input logic [12:0] mem_addr,
                                                  input logic [3:0] beat);
    return MEM_AW'(mem_addr) * MEM_AW'(BEATS) + MEM_AW'(beat);
  endfunction

endpackage

// File: rtl/dma_tile_engine_tile_beat_buffer.sv
// One-tile staging register: parallel load from the cache side, 32-bit
// beat writes from memory responses and 32-bit beat reads toward memory.
module tile_beat_buffer
  import cherry_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [TILE_WIDTH-1:0] load_data,
  input  logic                  wr_en,
  input  logic [3:0]            wr_idx,
  input  logic [MEM_DW-1:0]     wr_data,
  input  logic [3:0]            rd_idx,
  output logic [MEM_DW-1:0]     rd_data,
  output logic [TILE_WIDTH-1:0] tile
);

  always_ff @(posedge clk) begin
    if (reset) begin
      tile <= '0;
    end else if (load) begin
      tile <= load_data;
    end else if (wr_en) begin
      tile[wr_idx*MEM_DW +: MEM_DW] <= wr_data;
    end
  end

  assign rd_data = tile[rd_idx*MEM_DW +: MEM_DW];

endmodule

// File: rtl/dma_tile_engine.sv
// Moves one 288-bit tile per instruction between the dcache DMA ports and
// a 32-bit valid/ready memory bus, in either direction.
module dma_tile_engine
  import cherry_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     freeze,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic [21:0]              instr,
  output logic [21:0]              dma_read_port_in,
  input  logic [TILE_WIDTH+21:0]   dma_read_port_out,
  output logic [TILE_WIDTH+21:0]   dma_write_port,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic                     mem_req_we,
  output logic [MEM_AW-1:0]        mem_req_addr,
  output logic [MEM_DW-1:0]        mem_wdata,
  input  logic                     mem_rvalid,
  input  logic [MEM_DW-1:0]        mem_rdata,
  output logic                     busy,
  output logic                     done
);

  localparam logic [3:0] BEATS_N   = 4'(BEATS);
  localparam logic [3:0] LAST_BEAT = 4'(BEATS - 1);

  dma_state_t         state;
  dma_stage_1_instr_t instr_in;
  dma_stage_1_instr_t instr_q;
  dma_stage_1_instr_t rp;
  dma_stage_3_instr_t wp;
  logic [3:0]         beat;
  logic [3:0]         resp_cnt;
  logic [MEM_DW-1:0]  rd_data;
  logic [TILE_WIDTH-1:0] tile;
  logic               rsp_take;
  logic               last_resp;
  logic               last_beat;
  logic               unused_bits;

  assign instr_in    = instr;
  assign unused_bits = ^dma_read_port_out[TILE_WIDTH+21:TILE_WIDTH];

  // Responses are only meaningful while a load is in flight; anything else is dropped.
  assign rsp_take  = mem_rvalid && (state == M_REQ || state == M_RESP) && (resp_cnt < BEATS_N);
  assign last_resp = rsp_take && (resp_cnt == LAST_BEAT);
  assign last_beat = (beat == LAST_BEAT);

  tile_beat_buffer u_buf (
    .clk       (clk),
    .reset     (reset),
    .load      (state == C_CAPT),
    .load_data (dma_read_port_out[TILE_WIDTH-1:0]),
    .wr_en     (rsp_take),
    .wr_idx    (resp_cnt),
    .wr_data   (mem_rdata),
    .rd_idx    (beat),
    .rd_data   (rd_data),
    .tile      (tile)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      instr_q  <= '0;
      beat     <= '0;
      resp_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (instr_valid && !freeze && instr_in.raw_instr_data.valid) begin
            instr_q  <= instr_in;
            beat     <= '0;
            resp_cnt <= '0;
            state    <= instr_in.raw_instr_data.mem_we ? C_ISSUE : M_REQ;
          end
        end
        C_ISSUE: if (!freeze) state <= C_CAPT;
        C_CAPT:  state <= M_WR;
        M_WR: begin
          if (mem_req_ready) begin
            beat <= last_beat ? '0 : beat + 4'd1;
            if (last_beat) state <= IDLE;
          end
        end
        M_REQ: begin
          if (mem_req_ready) begin
            beat <= last_beat ? '0 : beat + 4'd1;
            if (last_beat) state <= last_resp ? W_CACHE : M_RESP;
          end
        end
        M_RESP:  if (last_resp || resp_cnt == BEATS_N) state <= W_CACHE;
        W_CACHE: if (!freeze) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (rsp_take) resp_cnt <= resp_cnt + 4'd1;
    end
  end

  always_comb begin
    rp = '0;
    if (state == C_ISSUE) begin
      rp = instr_q;
      rp.raw_instr_data.valid = 1'b1;
    end
  end

  always_comb begin
    wp = '0;
    if (state == W_CACHE) begin
      wp.instr = instr_q;
      wp.instr.raw_instr_data.valid  = 1'b1;
      wp.instr.raw_instr_data.mem_we = 1'b0;
      wp.dat = tile;
    end
  end

  assign dma_read_port_in = rp;
  assign dma_write_port   = wp;
  assign instr_ready      = (state == IDLE) && !freeze;
  assign busy             = (state != IDLE);
  assign mem_req_valid    = (state == M_WR) || (state == M_REQ);
  assign mem_req_we       = (state == M_WR);
  assign mem_req_addr     = mem_req_valid ? beat_addr(instr_q.raw_instr_data.mem_addr, beat) : '0;
  assign mem_wdata        = (state == M_WR) ? rd_data : '0;
  assign done             = ((state == M_WR) && mem_req_ready && last_beat) ||
                            ((state == W_CACHE) && !freeze);

endmodule

// File: tb/tb_dma_tile_engine.sv
// Directed bench for dma_tile_engine: memory and dcache models driven from
// one sequence, with expected beats and cache writes held in queues.
module tb_dma_tile_engine;
  import cherry_pkg::*;

  logic         clk = 1'b0;
  logic         reset, freeze, instr_valid, instr_ready;
  logic [21:0]  instr, dma_read_port_in;
  logic [309:0] dma_read_port_out, dma_write_port;
  logic         mem_req_valid, mem_req_ready, mem_req_we;
  logic [16:0]  mem_req_addr;
  logic [31:0]  mem_wdata, mem_rdata;
  logic         mem_rvalid, busy, done;

  dma_tile_engine dut (
    .clk(clk), .reset(reset), .freeze(freeze),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .dma_read_port_in(dma_read_port_in), .dma_read_port_out(dma_read_port_out),
    .dma_write_port(dma_write_port),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [48:0]  exp_wr_q[$];
  logic [16:0]  exp_rd_q[$];
  logic [309:0] exp_wp_q[$];
  logic [21:0]  exp_rp;
  logic [49:0]  stall_val;
  logic [16:0]  rsp_addr;
  int checks = 0, errors = 0, cyc = 0;
  int wr_beats = 0, rd_reqs = 0, rp_samples = 0, wp_writes = 0;
  int done_cnt = 0, done_cyc = 0, accept_cyc = 0, bp_cnt = 0, rd_base = 0;
  int w0, r0, p0, d0;
  bit bp_mode = 0, stray = 0, rsp_hit = 0, stall_prev = 0;

  task automatic check(input string tag, input logic [309:0] obs, input logic [309:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [287:0] pat(input logic [31:0] base);
    logic [287:0] t;
    for (int k = 0; k < 9; k++) t[32*k +: 32] = base + 32'(k);
    return t;
  endfunction

  function automatic logic [21:0] mk(input logic we, input logic [1:0] slot,
                                     input logic [4:0] caddr, input logic [12:0] maddr);
    return {1'b1, we, slot, caddr, maddr};
  endfunction

  // Negedge: observe DUT; posedge+1: drive memory response and ready pattern.
  task automatic tick();
    @(negedge clk);
    if (stall_prev && mem_req_valid)
      check("stall_hold", {mem_req_we, mem_req_addr, mem_wdata}, stall_val);
    stall_prev = mem_req_valid && !mem_req_ready;
    stall_val  = {mem_req_we, mem_req_addr, mem_wdata};
    if (mem_req_valid && mem_req_ready && mem_req_we) begin
      wr_beats++;
      if (exp_wr_q.size() == 0) check("wr_extra", 49'(exp_wr_q.size()), 49'd1);
      else check("wr_beat", {mem_req_addr, mem_wdata}, exp_wr_q.pop_front());
    end
    rsp_hit  = mem_req_valid && mem_req_ready && !mem_req_we;
    rsp_addr = mem_req_addr;
    if (rsp_hit) begin
      rd_reqs++;
      if (exp_rd_q.size() == 0) check("rd_extra", 17'(exp_rd_q.size()), 17'd1);
      else check("rd_addr", mem_req_addr, exp_rd_q.pop_front());
    end
    if (dma_read_port_in[21] && !freeze) begin
      rp_samples++;
      check("rp_val", dma_read_port_in, exp_rp);
    end
    if (dma_write_port[309] && !freeze) begin
      wp_writes++;
      if (exp_wp_q.size() == 0) check("wp_extra", 310'(exp_wp_q.size()), 310'd1);
      else check("wp_val", dma_write_port, exp_wp_q.pop_front());
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    @(posedge clk);
    cyc++;
    #1;
    mem_rvalid = rsp_hit || stray;
    mem_rdata  = stray ? 32'hDEAD_BEEF : 32'h1111_0000 + 32'(int'(rsp_addr) - rd_base * 9);
    stray = 0;
    if (bp_mode) begin
      mem_req_ready = (bp_cnt % 3 == 0);
      bp_cnt++;
    end
  endtask

  task automatic issue(input logic [21:0] i);
    instr = i;
    instr_valid = 1'b1;
    tick();
    accept_cyc = cyc;
    instr_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    int start = done_cnt;
    while (done_cnt == start && n < budget) begin
      tick();
      n++;
    end
    if (done_cnt == start) check("done_timeout", 310'(done_cnt - start), 310'd1);
  endtask

  task automatic push_store(input logic [12:0] maddr, input logic [31:0] base);
    for (int k = 0; k < 9; k++) begin
      int a = int'(maddr) * 9 + k;
      exp_wr_q.push_back({a[16:0], base + 32'(k)});
    end
  endtask

  task automatic push_load(input logic [12:0] maddr, input logic [1:0] slot, input logic [4:0] caddr);
    rd_base = int'(maddr);
    for (int k = 0; k < 9; k++) begin
      int a = int'(maddr) * 9 + k;
      exp_rd_q.push_back(a[16:0]);
    end
    exp_wp_q.push_back({1'b1, 1'b0, slot, caddr, maddr, pat(32'h1111_0000)});
  endtask

  initial begin
    reset = 1; freeze = 0; instr_valid = 0; instr = '0;
    dma_read_port_out = '0; mem_req_ready = 1; mem_rvalid = 0; mem_rdata = '0;
    exp_rp = '0;
    repeat (3) tick();
    reset = 0;
    tick();
    check("rst_busy", busy, 1'b0);
    check("rst_ready", instr_ready, 1'b1);
    check("rst_req_valid", mem_req_valid, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_wp", dma_write_port, '0);
    check("rst_rp", dma_read_port_in, '0);

    // Handshake with raw valid clear is consumed without starting a transfer.
    issue(22'h0F_1234 & 22'h1F_FFFF);
    tick();
    check("noop_busy", busy, 1'b0);

    // Store: cache tile A000000k to memory words 18..26.
    exp_rp = mk(1'b1, 2'd1, 5'd3, 13'd2);
    dma_read_port_out = {22'h0, pat(32'hA000_0000)};
    push_store(13'd2, 32'hA000_0000);
    w0 = wr_beats; r0 = rp_samples;
    issue(mk(1'b1, 2'd1, 5'd3, 13'd2));
    wait_done(40);
    check("st_latency", 310'(done_cyc - accept_cyc + 1), 310'd11);
    check("st_beats", 310'(wr_beats - w0), 310'd9);
    check("st_q_empty", 310'(exp_wr_q.size()), 310'd0);
    check("st_rp_samples", 310'(rp_samples - r0), 310'd1);

    // Load issued back-to-back, the cycle after done.
    push_load(13'd5, 2'd2, 5'd7);
    r0 = rd_reqs; p0 = wp_writes;
    issue(mk(1'b0, 2'd2, 5'd7, 13'd5));
    wait_done(40);
    check("ld_latency", 310'(done_cyc - accept_cyc + 1), 310'd11);
    check("ld_reqs", 310'(rd_reqs - r0), 310'd9);
    check("ld_writes", 310'(wp_writes - p0), 310'd1);
    check("ld_q_empty", 310'(exp_wp_q.size() + exp_rd_q.size()), 310'd0);

    // Backpressure on the store beats: ready follows 1,0,0,...
    exp_rp = mk(1'b1, SLOT_SINGLE_TILE, 5'd4, 13'd1);
    dma_read_port_out = {22'h0, pat(32'hC000_0000)};
    push_store(13'd1, 32'hC000_0000);
    w0 = wr_beats;
    bp_mode = 1; bp_cnt = 0;
    issue(mk(1'b1, SLOT_SINGLE_TILE, 5'd4, 13'd1));
    wait_done(100);
    bp_mode = 0; mem_req_ready = 1;
    check("bp_beats", 310'(wr_beats - w0), 310'd9);
    check("bp_q_empty", 310'(exp_wr_q.size()), 310'd0);

    // Freeze during C_ISSUE: the dcache is sampled exactly once after release.
    exp_rp = mk(1'b1, 2'd1, 5'd1, 13'd3);
    dma_read_port_out = {22'h0, pat(32'h5000_0000)};
    push_store(13'd3, 32'h5000_0000);
    r0 = rp_samples;
    issue(mk(1'b1, 2'd1, 5'd1, 13'd3));
    freeze = 1;
    repeat (3) tick();
    check("frz_issue_hold", dma_read_port_in, exp_rp);
    check("frz_ready", instr_ready, 1'b0);
    freeze = 0;
    wait_done(40);
    check("frz_st_latency", 310'(done_cyc - accept_cyc + 1), 310'd14);
    check("frz_rp_samples", 310'(rp_samples - r0), 310'd1);
    check("frz_st_q_empty", 310'(exp_wr_q.size()), 310'd0);

    // Freeze covering W_CACHE on a load; memory side keeps running.
    push_load(13'd6, 2'd3, 5'd12);
    p0 = wp_writes; d0 = done_cnt;
    issue(mk(1'b0, 2'd3, 5'd12, 13'd6));
    repeat (7) tick();
    freeze = 1;
    repeat (6) tick();
    check("frz_wc_hold", dma_write_port[309], 1'b1);
    check("frz_wc_nodone", 310'(done_cnt - d0), 310'd0);
    check("frz_wc_ready", instr_ready, 1'b0);
    freeze = 0;
    wait_done(40);
    check("frz_ld_latency", 310'(done_cyc - accept_cyc + 1), 310'd14);
    check("frz_ld_writes", 310'(wp_writes - p0), 310'd1);

    // Reset while the fifth store beat is on the bus.
    exp_rp = mk(1'b1, 2'd0, 5'd2, 13'd4);
    dma_read_port_out = {22'h0, pat(32'h7700_0000)};
    push_store(13'd4, 32'h7700_0000);
    w0 = wr_beats;
    issue(mk(1'b1, 2'd0, 5'd2, 13'd4));
    for (int n = 0; n < 40 && (wr_beats - w0) < 4; n++) tick();
    d0 = done_cnt;
    reset = 1;
    tick();
    reset = 0;
    check("mrst_busy", busy, 1'b0);
    check("mrst_req_valid", mem_req_valid, 1'b0);
    check("mrst_done", done, 1'b0);
    exp_wr_q.delete();
    stray = 1;
    tick();
    tick();
    check("stray_busy", busy, 1'b0);
    check("stray_nodone", 310'(done_cnt - d0), 310'd0);

    push_load(13'd0, 2'd1, 5'd9);
    p0 = wp_writes;
    issue(mk(1'b0, 2'd1, 5'd9, 13'd0));
    wait_done(40);
    check("post_rst_latency", 310'(done_cyc - accept_cyc + 1), 310'd11);
    check("post_rst_writes", 310'(wp_writes - p0), 310'd1);

    // Highest tile address: words 73719..73727.
    push_load(13'h1FFF, 2'd3, 5'd31);
    r0 = rd_reqs; p0 = wp_writes;
    issue(mk(1'b0, 2'd3, 5'd31, 13'h1FFF));
    wait_done(40);
    check("edge_reqs", 310'(rd_reqs - r0), 310'd9);
    check("edge_writes", 310'(wp_writes - p0), 310'd1);
    check("edge_q_empty", 310'(exp_rd_q.size() + exp_wp_q.size()), 310'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
